// File: rtl/game_sequencer.sv
// Flappy-bird game controller: frame tick, IDLE/PLAY/DEAD/CLEAR FSM, gap scheduling, score keeping.
// All outputs registered; button press to state change is 4 clocks, pipe_wrap/pipe_pass to output 1 clock; no backpressure.
module game_sequencer #(
  parameter int TICK_DIV = 2500000,
  parameter int GAP_MIN  = 40,
  parameter int GAP_MAX  = 360,
  parameter int SCORE_W  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               btn_flap,
  input  logic               btn_reset,
  input  logic               collision,
  input  logic [2:0]         pipe_wrap,
  input  logic [2:0]         pipe_pass,
  output logic               frame_tick,
  output logic               move_en,
  output logic               flap,
  output logic               game_reset,
  output logic [2:0]         gap_load,
  output logic [9:0]         gap_y,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_DEAD = 2'd2, S_CLEAR = 2'd3} state_t;

  localparam int              CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICK_DIV - 2);
  localparam logic [9:0]      GMIN     = 10'(GAP_MIN);
  localparam logic [9:0]      GRANGE   = 10'(GAP_MAX - GAP_MIN + 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_flap_sync, r_rst_sync;
  logic               r_flap_prev, r_rst_prev, r_flap_press, r_rst_press;
  logic               r_flap_pend, w_pend_nxt, w_flap_accept;
  logic               r_frame_tick, r_move_en, r_flap, r_game_reset;
  logic               w_tick_nxt, w_play_tick;
  logic [9:0]         r_lfsr, r_gap_y, w_raw, w_fold;
  logic [2:0]         r_pend_pipe, r_gap_load, w_srv, w_pick;
  logic [SCORE_W-1:0] r_score, r_high;
  logic [1:0]         w_pop;
  logic [SCORE_W:0]   w_sum;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_flap_press) w_state_nxt = S_PLAY;
      S_PLAY:  if (r_frame_tick && collision) w_state_nxt = S_DEAD;
      S_DEAD:  if (r_rst_press) w_state_nxt = S_CLEAR;
      S_CLEAR: if (r_frame_tick) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_flap_accept = r_flap_press && (r_state == S_IDLE || r_state == S_PLAY);
    w_pend_nxt    = (r_flap_pend & ~r_flap) | w_flap_accept;
    w_tick_nxt    = (r_cnt == CNT_PRE);
    w_play_tick   = w_tick_nxt && (w_state_nxt == S_PLAY);
    // Fold the 9-bit raw value into [GAP_MIN, GAP_MAX]; one subtraction suffices since range >= 256.
    w_raw  = {1'b0, r_lfsr[8:0]};
    w_fold = (w_raw < GRANGE) ? (GMIN + w_raw) : (GMIN + w_raw - GRANGE);
    w_srv  = r_pend_pipe | pipe_wrap;
    w_pick = w_srv & (~w_srv + 3'd1);
    w_pop  = {1'b0, pipe_pass[0]} + {1'b0, pipe_pass[1]} + {1'b0, pipe_pass[2]};
    w_sum  = {1'b0, r_score} + {{(SCORE_W-1){1'b0}}, w_pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_flap_sync  <= '0;
      r_rst_sync   <= '0;
      r_flap_prev  <= 1'b0;
      r_rst_prev   <= 1'b0;
      r_flap_press <= 1'b0;
      r_rst_press  <= 1'b0;
      r_flap_pend  <= 1'b0;
      r_frame_tick <= 1'b0;
      r_move_en    <= 1'b0;
      r_flap       <= 1'b0;
      r_game_reset <= 1'b1;
      r_lfsr       <= 10'h1A5;
      r_pend_pipe  <= '0;
      r_gap_load   <= '0;
      r_gap_y      <= GMIN;
      r_score      <= '0;
      r_high       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      r_flap_sync  <= {r_flap_sync[0], btn_flap};
      r_rst_sync   <= {r_rst_sync[0], btn_reset};
      r_flap_prev  <= r_flap_sync[1];
      r_rst_prev   <= r_rst_sync[1];
      r_flap_press <= r_flap_sync[1] & ~r_flap_prev;
      r_rst_press  <= r_rst_sync[1] & ~r_rst_prev;
      r_flap_pend  <= w_pend_nxt;
      r_frame_tick <= w_tick_nxt;
      r_move_en    <= w_play_tick;
      r_flap       <= w_play_tick & w_pend_nxt;
      r_game_reset <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_CLEAR);
      r_lfsr       <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
      if (r_game_reset) begin
        r_pend_pipe <= '0;
        r_gap_load  <= '0;
      end else begin
        r_pend_pipe <= w_srv & ~w_pick;
        r_gap_load  <= w_pick;
        if (|w_pick) r_gap_y <= w_fold;
      end
      if (w_state_nxt == S_IDLE)
        r_score <= '0;
      else if (r_state == S_PLAY)
        r_score <= w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
      if (r_state == S_DEAD && w_state_nxt == S_CLEAR && r_score > r_high)
        r_high <= r_score;
    end
  end

  assign frame_tick = r_frame_tick;
  assign move_en    = r_move_en;
  assign flap       = r_flap;
  assign game_reset = r_game_reset;
  assign gap_load   = r_gap_load;
  assign gap_y      = r_gap_y;
  assign score      = r_score;
  assign high_score = r_high;
  assign state      = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with TICK_DIV=4; a second instance with SCORE_W=3 checks saturation.
module tb_game_sequencer;
  logic       clk = 1'b0, reset_n = 1'b0;
  logic       btn_flap = 1'b0, btn_reset = 1'b0, collision = 1'b0;
  logic [2:0] pipe_wrap = 3'b000, pipe_pass = 3'b000;

  logic       frame_tick, move_en, flap, game_reset;
  logic [2:0] gap_load;
  logic [9:0] gap_y;
  logic [7:0] score, high_score;
  logic [1:0] state;

  logic       frame_tick_s, move_en_s, flap_s, game_reset_s;
  logic [2:0] gap_load_s;
  logic [9:0] gap_y_s;
  logic [2:0] score_s, high_score_s;
  logic [1:0] state_s;

  int total = 0;
  int bad   = 0;
  logic [9:0] m_lfsr, m_prev;

  game_sequencer #(.TICK_DIV(4), .GAP_MIN(40), .GAP_MAX(360), .SCORE_W(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .btn_flap(btn_flap), .btn_reset(btn_reset),
    .collision(collision), .pipe_wrap(pipe_wrap), .pipe_pass(pipe_pass),
    .frame_tick(frame_tick), .move_en(move_en), .flap(flap), .game_reset(game_reset),
    .gap_load(gap_load), .gap_y(gap_y), .score(score), .high_score(high_score), .state(state));

  game_sequencer #(.TICK_DIV(4), .GAP_MIN(40), .GAP_MAX(360), .SCORE_W(3)) u_dut_s (
    .clk(clk), .reset_n(reset_n), .btn_flap(btn_flap), .btn_reset(btn_reset),
    .collision(collision), .pipe_wrap(pipe_wrap), .pipe_pass(pipe_pass),
    .frame_tick(frame_tick_s), .move_en(move_en_s), .flap(flap_s), .game_reset(game_reset_s),
    .gap_load(gap_load_s), .gap_y(gap_y_s), .score(score_s), .high_score(high_score_s), .state(state_s));

  always #5 clk = ~clk;

  // Reference LFSR: x^10+x^7+1, seed 1A5; m_prev is the value seen before the latest edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_lfsr <= 10'h1A5;
      m_prev <= 10'h1A5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int fold(input logic [9:0] l);
    int raw;
    raw = int'(l[8:0]);
    if (raw < 321) return 40 + raw;
    return 40 + raw - 321;
  endfunction

  task automatic next_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 20);
    chk({tag, "_tick"}, int'(frame_tick), 1);
  endtask

  task automatic press(input logic f, input logic r);
    @(negedge clk);
    btn_flap  = f;
    btn_reset = r;
    repeat (5) @(negedge clk);
    btn_flap  = 1'b0;
    btn_reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pass_seq(input logic [2:0] p, input int exp_big, input int exp_small);
    pipe_pass = p;
    @(negedge clk);
    pipe_pass = 3'b000;
    chk("score", int'(score), exp_big);
    chk("score_s", int'(score_s), exp_small);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_move", int'(move_en), 0);
    chk("rst_flap", int'(flap), 0);
    chk("rst_greset", int'(game_reset), 1);
    chk("rst_gload", int'(gap_load), 0);
    chk("rst_gapy", int'(gap_y), 40);
    chk("rst_score", int'(score), 0);
    chk("rst_high", int'(high_score), 0);
    reset_n = 1'b1;

    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("tick_period", int'(frame_tick), (i % 4 == 3) ? 1 : 0);
    end

    // pipe_pass and pipe_wrap have no effect in IDLE
    pipe_pass = 3'b111;
    pipe_wrap = 3'b111;
    @(negedge clk);
    pipe_pass = 3'b000;
    pipe_wrap = 3'b000;
    chk("idle_score", int'(score), 0);
    chk("idle_gload", int'(gap_load), 0);

    btn_flap = 1'b1;
    repeat (3) @(negedge clk);
    chk("press_lat3", int'(state), 0);
    @(negedge clk);
    chk("press_lat4", int'(state), 1);
    chk("play_greset", int'(game_reset), 0);
    btn_flap = 1'b0;
    if (!frame_tick) next_tick("t1");
    chk("t1_move", int'(move_en), 1);
    chk("t1_flap", int'(flap), 1);
    next_tick("t2");
    chk("t2_move", int'(move_en), 1);
    chk("t2_flap", int'(flap), 0);

    @(negedge clk);
    pipe_wrap = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pipe_wrap = 3'b000;
      chk("gap_load", int'(gap_load), 1 << i);
      chk("gap_y", int'(gap_y), fold(m_prev));
      chk("gap_range", int'(gap_y >= 10'd40 && gap_y <= 10'd360), 1);
    end
    @(negedge clk);
    chk("gap_idle", int'(gap_load), 0);

    pass_seq(3'b111, 3, 3);
    pass_seq(3'b111, 6, 6);
    pass_seq(3'b011, 8, 7);

    next_tick("t3");
    @(negedge clk);
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    chk("mid_coll", int'(state), 1);

    next_tick("t4");
    chk("coll_move", int'(move_en), 1);
    collision = 1'b1;
    pipe_pass = 3'b001;
    @(negedge clk);
    collision = 1'b0;
    pipe_pass = 3'b000;
    chk("dead", int'(state), 2);
    chk("dead_score", int'(score), 9);
    chk("dead_score_s", int'(score_s), 7);

    pipe_pass = 3'b111;
    @(negedge clk);
    pipe_pass = 3'b000;
    chk("dead_nopass", int'(score), 9);
    press(1'b1, 1'b0);
    chk("dead_flap", int'(state), 2);
    next_tick("t5");
    chk("dead_move", int'(move_en), 0);
    chk("dead_flapout", int'(flap), 0);

    @(negedge clk);
    btn_flap  = 1'b1;
    btn_reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("clear", int'(state), 3);
    chk("clear_high", int'(high_score), 9);
    chk("clear_high_s", int'(high_score_s), 7);
    chk("clear_greset", int'(game_reset), 1);
    btn_flap  = 1'b0;
    btn_reset = 1'b0;
    if (!frame_tick) next_tick("t6");
    @(negedge clk);
    chk("idle_again", int'(state), 0);
    chk("idle_score0", int'(score), 0);
    chk("idle_greset", int'(game_reset), 1);

    repeat (3) @(negedge clk);
    press(1'b1, 1'b0);
    chk("game2", int'(state), 1);
    pass_seq(3'b111, 3, 3);
    pass_seq(3'b011, 5, 5);
    pass_seq(3'b011, 7, 7);
    next_tick("t7");
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    chk("dead2", int'(state), 2);
    press(1'b0, 1'b1);
    chk("high_kept", int'(high_score), 9);
    chk("high_kept_s", int'(high_score_s), 7);

    repeat (8) @(negedge clk);
    press(1'b1, 1'b0);
    chk("game3", int'(state), 1);
    pass_seq(3'b001, 1, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_score", int'(score), 0);
    chk("arst_high", int'(high_score), 0);
    chk("arst_greset", int'(game_reset), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
